mc_controller: RTL

- Multi-cycle MIPS control unit: Moore FSM sequencing one instruction over 3–5+ cycles through a shared ALU and a unified instruction/data memory.
- Decodes R-type (add/sub/and/or/slt), lw, sw, beq, addi and j.
- Adds a memory ready handshake, a sticky illegal-instruction flag and a state debug port.
- Sits between the instruction register and the multi-cycle datapath (PC, IR, register file, ALU, memory port).

---
 rtl/mc_controller.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mc_controller
//  Purpose  : Multi-cycle MIPS control unit. Moore FSM that sequences one
//             instruction through FETCH/DECODE/execute/write-back using a
//             shared ALU and a unified instruction/data memory, with a memory
//             ready handshake, a sticky illegal-instruction flag and a state
//             debug port.
//  Options  : define MC_BNE_EN to add the bne instruction (state 13).
//  Revision : 1.0 - initial release
// ============================================================================
module mc_controller #(
   parameter int ALUC_W = 3,   // alucontrol width, >= 3, upper bits tied low
   parameter int MEM_HS = 1    // 1 = honour mem_ready, 0 = single-cycle memory
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              iord,
   output logic              irwrite,
   output logic              memwrite,
   output logic              pcen,
   output logic              regwrite,
   output logic              regdst,
   output logic              memtoreg,
   output logic              alusrca,
   output logic [1:0]        alusrcb,
   output logic [1:0]        pcsrc,
   output logic [ALUC_W-1:0] alucontrol,
   output logic              illegal,
   output logic [3:0]        state
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BEQ    = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;
`ifdef MC_BNE_EN
   localparam logic [3:0] S_BNE    = 4'd13;
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   logic [3:0] state_q, state_d;
   logic       illegal_q, illegal_d;
   logic [5:0] op;
   logic [5:0] funct;
   logic       mem_rdy;
   logic       funct_ok;
   logic [2:0] funct_alu;
   logic [2:0] alu3;
   logic       unused_instr;

   assign op           = instr[31:26];
   assign funct        = instr[5:0];
   assign unused_instr = ^instr[25:6];

   // Without a handshake the memory is assumed to finish every access at once
   assign mem_rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

   // Map R-type funct to the ALU operation and flag unsupported codes
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_AND;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // State register and sticky illegal flag; async reset aborts mid-instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state sequencing and illegal-instruction detection
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
               OP_BNE:       state_d = S_BNE;
`endif
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         // Only lw and sw reach here, so anything but lw is a store
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
         S_EXEC: begin
            if (funct_ok) begin
               state_d = S_ALUWB;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_ALUWB:  state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
`ifdef MC_BNE_EN
         S_BNE:    state_d = S_FETCH;
`endif
         default:  state_d = S_IDLE;
      endcase
   end

   // Moore outputs; only FETCH (mem_rdy) and branches (zero) peek at inputs
   always_comb begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      alu3     = ALU_AND;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            alu3    = ALU_ADD;
            irwrite = mem_rdy;
            pcen    = mem_rdy;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            alu3    = ALU_ADD;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            alu3    = ALU_ADD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            alu3    = funct_alu;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         S_BEQ: begin
            alusrca = 1'b1;
            alu3    = ALU_SUB;
            pcsrc   = 2'b01;
            pcen    = zero;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            alu3    = ALU_ADD;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
`ifdef MC_BNE_EN
         S_BNE: begin
            alusrca = 1'b1;
            alu3    = ALU_SUB;
            pcsrc   = 2'b01;
            pcen    = ~zero;
         end
`endif
         default: ;
      endcase
   end

   // Widen the 3-bit ALU code; any extra upper bits stay low
   always_comb begin
      alucontrol      = '0;
      alucontrol[2:0] = alu3;
   end

   assign illegal = illegal_q;
   assign state   = state_q;

endmodule
`default_nettype wire
